// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed channel scanner for a multi-digit display.
// An internal sequencer walks through the channels one slot at a time. Each
// slot opens with a dead time in which every anode is off (anti-ghosting), and
// the rest of the slot shows the selected channel. Channels can be blanked.
// Optional feature macro: SCAN_MUX_SNAPSHOT_EN. When it is defined, the channel
// values are captured once per frame so that a frame never mixes old and new
// values. When it is undefined, data_in is shown live.
module display_scan_mux #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       blank_mask,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          sel,
  output logic [CHANNELS-1:0]       an_n,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [SEL_W-1:0]   selNext;
  logic               slotEnd;
  logic               frameEnd;
  logic               lit;
  logic               maskBit;
  logic [WIDTH-1:0]   chanVal;
  logic [CHANNELS*WIDTH-1:0] srcData;

  assign slotEnd  = (cnt == SLOT_LAST);
  assign frameEnd = en && (state == SHOW) && slotEnd && (sel == SEL_LAST);

`ifdef SCAN_MUX_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] shadow;

  // Capture the channel values on scan start and on every frame wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if ((state == IDLE && en) || frameEnd) begin
      shadow <= data_in;
    end
  end

  assign srcData = shadow;
`else
  assign srcData = data_in;
`endif

  // Sequencer registers: state, position inside the slot, and current channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      sel   <= selNext;
    end
  end

  // Next-state logic: dead time, then show, then advance to the next channel.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    selNext   = sel;
    if (!en) begin
      stateNext = IDLE;
      cntNext   = '0;
      selNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          cntNext   = '0;
          selNext   = '0;
          stateNext = (DEAD_CYCLES == 0) ? SHOW : DEAD;
        end
        DEAD: begin
          cntNext = cnt + CNT_W'(1);
          if (cnt == DEAD_LAST) begin
            stateNext = SHOW;
          end
        end
        SHOW: begin
          if (slotEnd) begin
            cntNext   = '0;
            selNext   = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            stateNext = (DEAD_CYCLES == 0) ? SHOW : DEAD;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
          selNext   = '0;
        end
      endcase
    end
  end

  // Pick the selected channel value and its blank bit.
  always_comb begin
    chanVal = '0;
    maskBit = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        chanVal = srcData[k*WIDTH +: WIDTH];
        maskBit = blank_mask[k];
      end
    end
  end

  assign lit = (state == SHOW) && !maskBit;

  // Registered display outputs and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out        <= '0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      if (lit) begin
        out  <= chanVal;
        an_n <= ~(CHANNELS'(1) << sel);
      end else begin
        out  <= '0;
        an_n <= '1;
      end
      frame_done <= frameEnd;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: scoreboard bench for display_scan_mux with
// CHANNELS=4, WIDTH=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// Honours SCAN_MUX_SNAPSHOT_EN to select the expected snapshot behaviour.
module tb_display_scan_mux;

  typedef struct packed {
    logic [3:0] anN;
    logic [3:0] outV;
    logic [1:0] selV;
    logic       fd;
  } exp_t;

`ifdef SCAN_MUX_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk;
  logic        resetN;
  logic        enV;
  logic [15:0] dataV;
  logic [3:0]  maskV;
  logic [3:0]  outW;
  logic [1:0]  selW;
  logic [3:0]  anW;
  logic        fdW;

  exp_t  expQ[$];
  string tagQ[$];
  int    total;
  int    bad;

  display_scan_mux #(
    .CHANNELS(4), .WIDTH(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(resetN), .en(enV), .data_in(dataV),
    .blank_mask(maskV), .out(outW), .sel(selW), .an_n(anW), .frame_done(fdW)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected values after the j-th edge of a scan (j=1 is the IDLE->DEAD edge).
  // Outputs reflect the sequencer as it stood after edge j-1: slot position
  // (j-2)%8, channel ((j-2)/8)%4, lit from position 2 onwards unless blanked.
  function automatic exp_t expectAt(int j, logic [15:0] d, logic [3:0] m);
    exp_t e;
    int   p;
    int   ps;
    e = '{anN: 4'hF, outV: 4'h0, selV: 2'd0, fd: 1'b0};
    e.selV = 2'(((j - 1) / 8) % 4);
    if (j >= 2) begin
      p  = j - 2;
      ps = (p / 8) % 4;
      if ((p % 8) >= 2 && !m[ps]) begin
        e.anN  = ~(4'b0001 << ps);
        e.outV = 4'((d >> (ps * 4)) & 16'h000F);
      end
      e.fd = ((p % 32) == 31);
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue what should appear after the next edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] d,
                               input logic [3:0] m, input exp_t x, input string tag);
    @(negedge clk);
    resetN = r;
    enV    = e;
    dataV  = d;
    maskV  = m;
    expQ.push_back(x);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput(input exp_t x, input string tag);
    total++;
    if (anW !== x.anN) begin
      bad++;
      $display("[TB] FAIL %s an_n: got %b want %b at %0t", tag, anW, x.anN, $time);
    end
    total++;
    if (outW !== x.outV) begin
      bad++;
      $display("[TB] FAIL %s out: got %0h want %0h at %0t", tag, outW, x.outV, $time);
    end
    total++;
    if (selW !== x.selV) begin
      bad++;
      $display("[TB] FAIL %s sel: got %0d want %0d at %0t", tag, selW, x.selV, $time);
    end
    total++;
    if (fdW !== x.fd) begin
      bad++;
      $display("[TB] FAIL %s frame_done: got %b want %b at %0t", tag, fdW, x.fd, $time);
    end
  endtask

  task automatic holdReset(int n, string tag);
    exp_t r;
    r = '{anN: 4'hF, outV: 4'h0, selV: 2'd0, fd: 1'b0};
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 16'h4321, 4'h0, r, tag);
  endtask

  task automatic scanEdges(int jFrom, int jTo, logic [15:0] d, logic [3:0] m, string tag);
    for (int j = jFrom; j <= jTo; j++) applyStimulus(1'b1, 1'b1, d, m, expectAt(j, d, m), tag);
  endtask

  // Monitor: pop and compare one expectation per clock edge.
  initial begin
    exp_t  x;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(x, t);
      end
    end
  end

  // Directed scenarios.
  initial begin
    exp_t x;
    total  = 0;
    bad    = 0;
    resetN = 1'b0;
    enV    = 1'b1;
    dataV  = 16'h4321;
    maskV  = 4'h0;

    holdReset(5, "reset");
    scanEdges(1, 70, 16'h4321, 4'h0, "basic");

    holdReset(1, "rst2");
    scanEdges(1, 70, 16'h4321, 4'b0100, "blank");

    holdReset(1, "rst3");
    scanEdges(1, 20, 16'h4321, 4'h0, "pre_endrop");
    x = '{anN: 4'b1011, outV: 4'h3, selV: 2'd0, fd: 1'b0};
    applyStimulus(1'b1, 1'b0, 16'h4321, 4'h0, x, "endrop_edge");
    x = '{anN: 4'hF, outV: 4'h0, selV: 2'd0, fd: 1'b0};
    applyStimulus(1'b1, 1'b0, 16'h4321, 4'h0, x, "endrop_idle");
    applyStimulus(1'b1, 1'b0, 16'h4321, 4'h0, x, "endrop_idle2");
    scanEdges(1, 14, 16'h4321, 4'h0, "restart");

    holdReset(1, "rst4");
    scanEdges(1, 32, 16'h4321, 4'h0, "pre_midrst");
    holdReset(2, "midrst");
    scanEdges(1, 12, 16'h4321, 4'h0, "after_midrst");

    holdReset(1, "rst5");
    scanEdges(1, 12, 16'h4321, 4'h0, "snap_pre");
    for (int j = 13; j <= 70; j++) begin
      x = expectAt(j, (SNAP && j <= 33) ? 16'h4321 : 16'h8765, 4'h0);
      applyStimulus(1'b1, 1'b1, 16'h8765, 4'h0, x, "snap");
    end

    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
